// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared definitions for the UART transmit frame controller: FSM state
// encoding, TX output-mux select codes and the state-to-mux decode.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // Idle and stop both drive the line high, so they share a select code
  function automatic logic [1:0] mux_of(input state_e s);
    logic [1:0] m;
    case (s)
      ST_START:  m = MUX_START;
      ST_DATA:   m = MUX_DATA;
      ST_PARITY: m = MUX_PAR;
      ST_STOP:   m = MUX_STOP;
      ST_IDLE:   m = MUX_STOP;
      default:   m = MUX_STOP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Payload handshake and TX-mux control bundle between the frame
// controller and its user.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/uart_tx_frame_ctrl_parity_calc.sv
// Combinational parity generator: even parity for par_typ=0, odd for
// par_typ=1.
module parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par
);

  function automatic logic xor_reduce(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  assign par = xor_reduce(data) ^ par_typ;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: sequences start, LSB-first payload,
// optional parity and stop slots through a 4:1 TX output mux select.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_frame_ctrl_if.slave  tx
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  state_e                state_r;
  state_e                nxt_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  par_en_r;
  logic                  par_r;
  logic [1:0]            mux_r;
  logic                  busy_r;
  logic                  accept_s;
  logic                  last_s;
  logic                  par_s;

  parity_calc #(
    .WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (tx.P_DATA),
    .par_typ (tx.PAR_TYP),
    .par     (par_s)
  );

  // A new payload is only taken when the line is idle or finishing a stop slot
  assign accept_s = tx.Data_Valid && ((state_r == ST_IDLE) || (state_r == ST_STOP));
  assign last_s   = (cnt_r == CNT_W'(DATA_WIDTH - 1));

  // Next-state decode
  always_comb begin
    nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) nxt_s = ST_START;
        else          nxt_s = ST_IDLE;
      end
      ST_START:  nxt_s = ST_DATA;
      ST_DATA: begin
        if (!last_s)       nxt_s = ST_DATA;
        else if (par_en_r) nxt_s = ST_PARITY;
        else               nxt_s = ST_STOP;
      end
      ST_PARITY: nxt_s = ST_STOP;
      ST_STOP: begin
        if (accept_s) nxt_s = ST_START;
        else          nxt_s = ST_IDLE;
      end
      default:   nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, payload datapath and registered mux/busy outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      shift_r  <= {DATA_WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      par_en_r <= 1'b0;
      par_r    <= 1'b0;
      mux_r    <= MUX_STOP;
      busy_r   <= 1'b0;
    end else begin
      state_r <= nxt_s;
      mux_r   <= mux_of(nxt_s);
      busy_r  <= (nxt_s != ST_IDLE);
      if (accept_s) begin
        shift_r  <= tx.P_DATA;
        par_en_r <= tx.PAR_EN;
        par_r    <= par_s;
        cnt_r    <= {CNT_W{1'b0}};
      end else if (state_r == ST_DATA) begin
        // Counter may reach DATA_WIDTH on the last bit; the extra MSB keeps it from wrapping
        shift_r <= shift_r >> 1;
        cnt_r   <= cnt_r + CNT_W'(1);
      end else if (state_r == ST_START) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign tx.mux_sel  = mux_r;
  assign tx.busy     = busy_r;
  assign tx.ser_data = shift_r[0];
  assign tx.par_bit  = par_r;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: table of single frames plus
// directed sequences for mid-frame strobes, back-to-back frames and reset.
module tb_uart_tx_frame_ctrl;

  logic clk;
  logic rst;
  logic line_s;
  int   pass_cnt;
  int   total_cnt;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(8)) tx_if ();

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .tx  (tx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial line level as the downstream 4:1 mux would produce it
  always_comb begin
    case (tx_if.mux_sel)
      2'b00:   line_s = 1'b0;
      2'b01:   line_s = 1'b1;
      2'b10:   line_s = tx_if.ser_data;
      2'b11:   line_s = tx_if.par_bit;
      default: line_s = 1'bx;
    endcase
  end

  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        typ;
    logic [23:0] exp_line;
    int          exp_len;
    logic        exp_par;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Starts a frame from IDLE and records the line while busy; optionally
  // re-strobes Data_Valid at capture index inj_at with payload inj_d.
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic typ,
                           input int inj_at, input logic [7:0] inj_d,
                           output logic [23:0] cap, output int blen);
    cap = 24'h000000;
    blen = 0;
    tx_if.P_DATA = d;
    tx_if.PAR_EN = pen;
    tx_if.PAR_TYP = typ;
    tx_if.Data_Valid = 1'b1;
    @(posedge clk); #1;
    tx_if.Data_Valid = 1'b0;
    tx_if.P_DATA = 8'h00;
    while (tx_if.busy && blen < 24) begin
      cap[blen] = line_s;
      if (blen == inj_at) begin
        tx_if.Data_Valid = 1'b1;
        tx_if.P_DATA = inj_d;
        tx_if.PAR_EN = 1'b0;
        tx_if.PAR_TYP = 1'b1;
      end else begin
        tx_if.Data_Valid = 1'b0;
      end
      blen++;
      @(posedge clk); #1;
    end
    tx_if.Data_Valid = 1'b0;
  endtask

  initial begin
    logic [23:0] cap;
    int          blen;

    pass_cnt = 0;
    total_cnt = 0;
    // Line bit i is the level in frame cycle i (start first)
    vecs[0] = '{8'hA5, 1'b0, 1'b0, {14'd0, 10'b1101001010},  10, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, {13'd0, 11'b10101001010}, 11, 1'b0};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, {13'd0, 11'b11101001010}, 11, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, {14'd0, 10'b1010110100},  10, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, {13'd0, 11'b11001111000}, 11, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 1'b0, {13'd0, 11'b11000000010}, 11, 1'b1};

    rst = 1'b0;
    tx_if.P_DATA = 8'h00;
    tx_if.Data_Valid = 1'b0;
    tx_if.PAR_EN = 1'b0;
    tx_if.PAR_TYP = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mux_sel", 32'(tx_if.mux_sel), 32'h1);
    chk("reset_busy", 32'(tx_if.busy), 32'h0);
    chk("reset_ser_data", 32'(tx_if.ser_data), 32'h0);
    chk("reset_par_bit", 32'(tx_if.par_bit), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].data, vecs[i].pen, vecs[i].typ, -1, 8'h00, cap, blen);
      chk($sformatf("vec%0d_line", i), 32'(cap), 32'(vecs[i].exp_line));
      chk($sformatf("vec%0d_busy_len", i), 32'(blen), 32'(vecs[i].exp_len));
      chk($sformatf("vec%0d_par_bit", i), 32'(tx_if.par_bit), 32'(vecs[i].exp_par));
      @(posedge clk); #1;
    end

    // Strobe during the 3rd data cycle must not disturb the A5 frame
    run_frame(8'hA5, 1'b0, 1'b0, 3, 8'hFF, cap, blen);
    chk("ignore_dv_line", 32'(cap), 32'(10'b1101001010));
    chk("ignore_dv_len", 32'(blen), 32'd10);
    chk("ignore_dv_par", 32'(tx_if.par_bit), 32'h0);
    @(posedge clk); #1;

    // Strobe in the stop slot chains a 3C frame with busy held high throughout
    run_frame(8'hA5, 1'b0, 1'b0, 9, 8'h3C, cap, blen);
    chk("b2b_line", 32'(cap), 32'({4'd0, 10'b1001111000, 10'b1101001010}));
    chk("b2b_len", 32'(blen), 32'd20);
    chk("b2b_par", 32'(tx_if.par_bit), 32'h1);
    @(posedge clk); #1;

    // Reset in the 5th data cycle of an odd-parity A5 frame
    tx_if.P_DATA = 8'hA5;
    tx_if.PAR_EN = 1'b0;
    tx_if.PAR_TYP = 1'b1;
    tx_if.Data_Valid = 1'b1;
    @(posedge clk); #1;
    tx_if.Data_Valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_mux_sel", 32'(tx_if.mux_sel), 32'h2);
    chk("pre_rst_ser_data", 32'(tx_if.ser_data), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_mux_sel", 32'(tx_if.mux_sel), 32'h1);
    chk("mid_rst_busy", 32'(tx_if.busy), 32'h0);
    chk("mid_rst_ser_data", 32'(tx_if.ser_data), 32'h0);
    chk("mid_rst_par_bit", 32'(tx_if.par_bit), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(8'h5A, 1'b0, 1'b0, -1, 8'h00, cap, blen);
    chk("post_rst_line", 32'(cap), 32'(10'b1010110100));
    chk("post_rst_len", 32'(blen), 32'd10);
    @(posedge clk); #1;

    // Data_Valid coincident with reset must not start a frame
    rst = 1'b0;
    tx_if.P_DATA = 8'hA5;
    tx_if.Data_Valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    tx_if.Data_Valid = 1'b0;
    chk("dv_rst_busy0", 32'(tx_if.busy), 32'h0);
    chk("dv_rst_mux0", 32'(tx_if.mux_sel), 32'h1);
    @(posedge clk); #1;
    chk("dv_rst_busy1", 32'(tx_if.busy), 32'h0);
    chk("dv_rst_mux1", 32'(tx_if.mux_sel), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, payload bits per frame.
REQ-002 Port: CLK  in  1  single system clock; all logic on rising edge.
REQ-003 Port: RST  in  1  reset, synchronous, active-low.
REQ-004 Port: P_DATA  in  DATA_WIDTH  parallel payload, sampled only on acceptance.
REQ-005 Port: Data_Valid  in  1  payload-valid strobe.
REQ-006 Port: PAR_EN  in  1  parity enable, sampled on acceptance.
REQ-007 Port: PAR_TYP  in  1  parity type, 0 = even and 1 = odd, sampled on acceptance.
REQ-008 Port: mux_sel  out  2  select to the TX output 4:1 mux: 00 start (0), 01 stop/idle (1), 10 ser_data, 11 par_bit.
REQ-009 Port: ser_data  out  1  current payload bit, LSB first.
REQ-010 Port: par_bit  out  1  parity of the latched payload.
REQ-011 Port: busy  out  1  high while a frame is in progress.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, START, DATA, PARITY, STOP, and all outputs decoded from registered state and datapath.
REQ-013 Acceptance SHALL occur when Data_Valid=1 in IDLE or STOP: load P_DATA into the shift register, latch PAR_EN/PAR_TYP, compute par_bit, and enter START next cycle.
REQ-014 Data_Valid in START, DATA or PARITY SHALL be ignored with no effect on the frame or the latched data.
REQ-015 IDLE: mux_sel=01, busy=0.
REQ-016 START: 1 cycle, mux_sel=00, busy=1, then DATA.
REQ-017 DATA: exactly DATA_WIDTH cycles, mux_sel=10, ser_data=shift_reg[0], shift right by one each cycle, bit counter increments from 0 to DATA_WIDTH-1.
REQ-018 After the last DATA cycle, the FSM SHALL enter PARITY if latched PAR_EN=1, and STOP otherwise.
REQ-019 PARITY: 1 cycle, mux_sel=11, busy=1, then STOP.
REQ-020 STOP: 1 cycle, mux_sel=01, busy=1, then IDLE, or START if a new payload is accepted (REQ-013), giving back-to-back frames with no idle gap.
REQ-021 par_bit SHALL be the XOR-reduction of the payload when PAR_TYP=0, and its complement when PAR_TYP=1, and SHALL hold until the next acceptance.
REQ-022 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-023 The bit counter SHALL be log2(DATA_WIDTH)+1 bits wide, with no wrap-around permitted within a frame.

Reset
REQ-024 RST=0 at a clock edge SHALL force IDLE, mux_sel=01, busy=0, and shift register, counter, par_bit and ser_data all 0, from any state including mid-frame.
REQ-025 Data_Valid coincident with RST=0 SHALL be ignored.

Structure
REQ-026 Package uart_tx_pkg SHALL hold the state encoding and the four mux_sel constants (MUX_START, MUX_STOP, MUX_DATA, MUX_PAR).
REQ-027 Parity computation SHALL be a sub-module parity_calc (inputs: data, type; output: bit), instantiated once.

Verification
REQ-028 P_DATA=0xA5, PAR_EN=0: line sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high for exactly 10 cycles.
REQ-029 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0: parity slot=0; with PAR_TYP=1: parity slot=1; busy high 11 cycles.
REQ-030 Data_Valid pulsed again in the 3rd DATA cycle with P_DATA=0xFF: the frame continues transmitting 0xA5 unchanged.
REQ-031 Data_Valid held high in the STOP cycle with P_DATA=0x3C: START follows STOP immediately, busy never drops, second frame bits are 0,0,1,1,1,1,0,0.
REQ-032 RST=0 asserted in the 5th DATA cycle: the next cycle shows mux_sel=01 and busy=0; a new 0x5A frame after reset release is correct.
REQ-033 Data_Valid and RST=0 asserted in the same cycle: the block stays IDLE and no frame starts.
